// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcodes, flag indices and controller state shared with the ALU.
// Rev 1.0
// ============================================================================
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_XNOR = 4'b1001;
  localparam logic [3:0] OP_EQ   = 4'b1010;
  localparam logic [3:0] OP_GT   = 4'b1011;
  localparam logic [3:0] OP_LT   = 4'b1100;
  localparam logic [3:0] OP_SHR  = 4'b1101;
  localparam logic [3:0] OP_SHL  = 4'b1110;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ARITH = 1;
  localparam int FLAG_LOGIC = 2;
  localparam int FLAG_CMP   = 3;
  localparam int FLAG_SHIFT = 4;

  localparam int WAIT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Commands the ALU must never see: divide-by-zero and the unused opcode.
  function automatic logic is_illegal(input logic [3:0] fun, input logic [15:0] b);
    return (fun == OP_NOP) || ((fun == OP_DIV) && (b == 16'h0000));
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// alu_cmd_ctrl : issues screened commands to the registered ALU and returns
//                the captured result and flags over a valid/ready response.
// Rev 1.0
// ============================================================================
module alu_cmd_ctrl
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_fun,
  input  logic [15:0]      cmd_a,
  input  logic [15:0]      cmd_b,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [3:0]       alu_fun,
  input  logic [15:0]      alu_out,
  input  logic [4:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic [4:0]       rsp_flags,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(ALU_LAT - 1);

  state_t            state_q;
  logic [WAIT_W-1:0] wait_q;
  logic              cmd_ready_q;
  logic [15:0]       alu_a_q;
  logic [15:0]       alu_b_q;
  logic [3:0]        alu_fun_q;
  logic              rsp_valid_q;
  logic [15:0]       rsp_data_q;
  logic [4:0]        rsp_flags_q;
  logic              rsp_err_q;
  logic [CNT_W-1:0]  op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      cmd_ready_q <= 1'b1;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= OP_NOP;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready_q <= 1'b0;
            if (is_illegal(cmd_fun, cmd_b)) begin
              // Rejected commands bypass the ALU entirely; alu_fun stays NOP.
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
              rsp_flags_q <= '0;
            end else begin
              state_q   <= ST_EXEC;
              wait_q    <= '0;
              alu_a_q   <= cmd_a;
              alu_b_q   <= cmd_b;
              alu_fun_q <= cmd_fun;
            end
          end
        end

        ST_EXEC: begin
          if (wait_q == LAST_WAIT) begin
            state_q <= ST_CAPT;
          end else begin
            wait_q <= wait_q + 3'd1;
          end
        end

        ST_CAPT: begin
          state_q     <= ST_RESP;
          rsp_data_q  <= alu_out;
          rsp_flags_q <= alu_flags;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          alu_fun_q   <= OP_NOP;
        end

        ST_RESP: begin
          // The IDLE cycle after consume keeps accept and consume on separate edges.
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            op_count_q  <= op_count_q + CNT_W'(1);
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          alu_fun_q   <= OP_NOP;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_fun   = alu_fun_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;
  assign op_count  = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// tb_alu_cmd_ctrl : controller driving a behavioural registered ALU, with a
//                   scoreboard checking every response.
// Rev 1.0
// ============================================================================
module tb_alu_cmd_ctrl;
  import alu_pkg::*;

  localparam int ALU_LAT = 1;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_fun = 4'h0;
  logic [15:0]      cmd_a = 16'h0;
  logic [15:0]      cmd_b = 16'h0;
  logic [15:0]      alu_a;
  logic [15:0]      alu_b;
  logic [3:0]       alu_fun;
  logic [15:0]      alu_out;
  logic [4:0]       alu_flags;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [15:0]      rsp_data;
  logic [4:0]       rsp_flags;
  logic             rsp_err;
  logic [CNT_W-1:0] op_count;

  alu_cmd_ctrl #(.ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fun(cmd_fun),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {flags, result}, flags {Shift,CMP,Logic,Arith,Carry}.
  function automatic logic [20:0] ref_alu(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] wa, wb, r;
    logic [4:0]  fl;
    wa = {16'h0, a};
    wb = {16'h0, b};
    r  = 0;
    fl = 5'b0;
    case (f)
      4'h0: begin r = wa + wb; fl[0] = r[16]; fl[1] = 1'b1; end
      4'h1: begin r = wa - wb; fl[0] = (a < b); fl[1] = 1'b1; end
      4'h2: begin r = wa * wb; fl[1] = 1'b1; end
      4'h3: begin r = (b == 0) ? 0 : wa / wb; fl[1] = 1'b1; end
      4'h4: begin r = wa & wb; fl[2] = 1'b1; end
      4'h5: begin r = wa | wb; fl[2] = 1'b1; end
      4'h6: begin r = ~(wa & wb); fl[2] = 1'b1; end
      4'h7: begin r = ~(wa | wb); fl[2] = 1'b1; end
      4'h8: begin r = wa ^ wb; fl[2] = 1'b1; end
      4'h9: begin r = ~(wa ^ wb); fl[2] = 1'b1; end
      4'hA: begin r = (a == b) ? 1 : 0; fl[3] = 1'b1; end
      4'hB: begin r = (a > b) ? 2 : 0; fl[3] = 1'b1; end
      4'hC: begin r = (a < b) ? 3 : 0; fl[3] = 1'b1; end
      4'hD: begin r = wa >> 1; fl[4] = 1'b1; end
      4'hE: begin r = wa << 1; fl[4] = 1'b1; end
      default: begin r = 0; fl = 5'b0; end
    endcase
    return {fl, r[15:0]};
  endfunction

  logic [20:0] pipe [ALU_LAT];
  initial for (int i = 0; i < ALU_LAT; i++) pipe[i] = 21'h0;
  always @(posedge clk) begin
    pipe[0] <= ref_alu(alu_fun, alu_a, alu_b);
    for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_out   = pipe[ALU_LAT-1][15:0];
  assign alu_flags = pipe[ALU_LAT-1][20:16];

  typedef struct {
    logic [15:0] data;
    logic [4:0]  flags;
    logic        err;
    int          acc_edge;
    int          lat;
  } exp_t;

  exp_t             sb[$];
  int               cyc = 0;
  int               n_vec = 0;
  int               n_cmp = 0;
  int               n_fail = 0;
  int               last_consume = -10;
  logic [CNT_W-1:0] model_cnt = '0;
  logic             hold_low = 1'b0;

  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Issued at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [20:0] r;
    logic        ill;
    bit          waited;
    int          budget;
    waited = 0;
    budget = 0;
    cmd_valid = 1'b1; cmd_fun = f; cmd_a = a; cmd_b = b;
    while (!cmd_ready && budget < 200) begin
      @(posedge clk); #1;
      waited = 1;
      budget++;
    end
    if (!cmd_ready) begin
      fail_now("accept_timeout", "cmd_ready stayed 0, expected 1 within 200 cycles");
      cmd_valid = 1'b0;
      return;
    end
    ill = (f == 4'hF) || (f == 4'h3 && b == 16'h0);
    r = ill ? 21'h0 : ref_alu(f, a, b);
    e.data = r[15:0];
    e.flags = r[20:16];
    e.err = ill;
    e.acc_edge = cyc + 1;
    e.lat = ill ? 1 : ALU_LAT + 2;
    sb.push_back(e);
    n_vec++;
    if (waited) chk("accept_after_consume", cyc + 1, last_consume + 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_fun = 4'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((sb.size() != 0 || rsp_valid) && budget < 500) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 500) fail_now("drain_timeout", "responses still pending after 500 cycles");
  endtask

  task automatic check_reset_vals();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_fun", alu_fun, 4'hF);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_op_count", op_count, 0);
  endtask

  initial forever begin
    @(posedge clk); #1;
    rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops on each new response, then watches it until consumed.
  initial begin
    bit          pv, pr;
    logic [15:0] hd;
    logic [4:0]  hf;
    logic        he;
    exp_t        e;
    pv = 0; pr = 0; hd = '0; hf = '0; he = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0;
        pr = 0;
      end else begin
        if (rsp_valid && !pv) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_rsp", "rsp_valid=1 with no command outstanding, expected 0");
          end else begin
            e = sb.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_flags", rsp_flags, e.flags);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_latency", cyc - e.acc_edge + 1, e.lat);
            chk("op_count", op_count, model_cnt);
          end
          hd = rsp_data; hf = rsp_flags; he = rsp_err;
        end else if (rsp_valid && pv) begin
          if (pr) begin
            fail_now("rsp_consume", "rsp_valid=1 after consume, expected 0");
          end else begin
            chk("hold_data", rsp_data, hd);
            chk("hold_flags", rsp_flags, hf);
            chk("hold_err", rsp_err, he);
          end
        end
        if (rsp_valid) begin
          chk("busy_cmd_ready", cmd_ready, 0);
          chk("resp_alu_fun", alu_fun, 4'hF);
        end
        if (cmd_ready) chk("idle_alu_fun", alu_fun, 4'hF);
        if (rsp_valid && rsp_ready) begin
          model_cnt = model_cnt + 1'b1;
          last_consume = cyc + 1;
        end
        pv = rsp_valid;
        pr = rsp_ready;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;

    send(4'h0, 16'hFFFF, 16'h0001);
    drain();
    send(4'h3, 16'd10, 16'd0);
    send(4'h3, 16'd100, 16'd7);
    drain();
    send(4'hB, 16'd5, 16'd3);
    send(4'hC, 16'd5, 16'd3);
    drain();

    hold_low = 1'b1;
    fork
      begin
        send(4'h1, 16'h1234, 16'h2345);
        send(4'h8, 16'hA5A5, 16'h0FF0);
      end
      begin
        int b;
        b = 0;
        while (!rsp_valid && b < 100) begin @(posedge clk); #1; b++; end
        repeat (5) @(posedge clk);
        #1 hold_low = 1'b0;
      end
    join
    drain();

    // Reset lands while the SHL is in EXEC; nothing may come back from it.
    send(4'hE, 16'h8001, 16'h0000);
    rst_n = 1'b0;
    sb.delete();
    model_cnt = '0;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", rsp_valid, 0);
    end
    @(posedge clk); #1;

    send(4'hE, 16'h8001, 16'h0000);
    for (int i = 0; i < 15; i++) begin
      if (i == 7) send(4'hF, 16'($urandom), 16'($urandom));
      else send(4'($urandom_range(0, 14)), 16'($urandom), 16'($urandom_range(1, 65535)));
    end
    drain();
    @(negedge clk);
    chk("op_count_wrap", op_count, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  f;
      logic [15:0] b;
      f = 4'($urandom);
      b = 16'($urandom);
      if (f == 4'h3 && $urandom_range(0, 2) == 0) b = 16'h0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(f, 16'($urandom), b);
    end
    drain();
    @(negedge clk);
    chk("final_op_count", op_count, model_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
